// File: rtl/fp_cvt_ctrl_if.sv
// rtl/fp_cvt_ctrl_if.sv - request/response/flag bundle between FP issue, fp_cvt_ctrl and writeback
interface fp_cvt_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_flush;
    logic                  in_req_valid;
    logic                  out_req_ready;
    logic [DATA_WIDTH-1:0] in_req_data;
    logic                  in_req_sp_dp;
    logic [TAG_WIDTH-1:0]  in_req_tag;
    logic                  out_rsp_valid;
    logic                  in_rsp_ready;
    logic [DATA_WIDTH-1:0] out_rsp_data;
    logic [TAG_WIDTH-1:0]  out_rsp_tag;
    logic                  out_rsp_nx;
    logic                  out_fflags_nx;
    logic                  in_fflags_clr;
    logic                  out_busy;

    modport master (
        output in_flush, in_req_valid, in_req_data, in_req_sp_dp, in_req_tag,
               in_rsp_ready, in_fflags_clr,
        input  out_req_ready, out_rsp_valid, out_rsp_data, out_rsp_tag,
               out_rsp_nx, out_fflags_nx, out_busy
    );

    modport slave (
        input  in_flush, in_req_valid, in_req_data, in_req_sp_dp, in_req_tag,
               in_rsp_ready, in_fflags_clr,
        output out_req_ready, out_rsp_valid, out_rsp_data, out_rsp_tag,
               out_rsp_nx, out_fflags_nx, out_busy
    );
endinterface

// File: rtl/fp_cvt_ctrl.sv
// rtl/fp_cvt_ctrl.sv - FCVT.D.S / FCVT.S.D sequencing controller with embedded RNE converter
module fp_cvt_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = 5
) (
    input  logic          in_clk,
    input  logic          in_rst,
    fp_cvt_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] op_q;
    logic                  sp_dp_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;
    logic                  rsp_nx_q;
    logic                  fflags_nx_q;
    logic                  req_ready, accept, rsp_hs;
    logic [DATA_WIDTH-1:0] op_qual;

    // SP operands that are not properly NaN-boxed read as the canonical SP NaN
    assign op_qual = (!bus.in_req_sp_dp && bus.in_req_data[63:32] != 32'hFFFFFFFF)
                   ? 64'hFFFFFFFF_7FC00000 : bus.in_req_data;

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        case (state)
            IDLE:    req_ready = 1'b1;
            DONE:    req_ready = bus.in_rsp_ready;
            default: req_ready = 1'b0;
        endcase
        if (bus.in_flush || in_rst) req_ready = 1'b0;
        accept = bus.in_req_valid & req_ready;
        rsp_hs = (state == DONE) & bus.in_rsp_ready & ~bus.in_flush;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    state_nxt = DONE;
            DONE:    if (bus.in_rsp_ready) state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.in_flush) state_nxt = IDLE;
    end

    logic        s_sgn, d_sgn;
    logic [7:0]  s_exp;
    logic [22:0] s_man, s_norm, keep;
    logic [4:0]  s_lz;
    logic [10:0] d_exp, sh;
    logic [51:0] d_man;
    logic [78:0] wide;
    logic [30:0] mag;
    logic        guard, sticky, round_up;
    logic [63:0] cvt_data;
    logic        cvt_nx;

    always_comb begin
        cvt_data = '0;
        cvt_nx   = 1'b0;
        s_lz     = '0;
        s_norm   = '0;
        sh       = '0;
        wide     = '0;
        keep     = '0;
        mag      = '0;
        guard    = 1'b0;
        sticky   = 1'b0;
        round_up = 1'b0;
        s_sgn    = op_q[31];
        s_exp    = op_q[30:23];
        s_man    = op_q[22:0];
        d_sgn    = op_q[63];
        d_exp    = op_q[62:52];
        d_man    = op_q[51:0];
        if (!sp_dp_q) begin
            // SP->DP is always exact; SP subnormals become DP normals
            if (s_exp == 8'hFF) begin
                cvt_data = (s_man != '0) ? 64'h7FF8000000000000 : {s_sgn, 11'h7FF, 52'd0};
            end else if (s_exp == 8'd0) begin
                if (s_man == '0) begin
                    cvt_data = {s_sgn, 63'd0};
                end else begin
                    for (int i = 0; i < 23; i++) if (s_man[i]) s_lz = 5'(22 - i);
                    s_norm   = s_man << (s_lz + 5'd1);
                    cvt_data = {s_sgn, 11'd896 - {6'd0, s_lz}, s_norm, 29'd0};
                end
            end else begin
                cvt_data = {s_sgn, {3'd0, s_exp} + 11'd896, s_man, 29'd0};
            end
        end else begin
            if (d_exp == 11'h7FF) begin
                cvt_data = {32'hFFFFFFFF, (d_man != '0) ? 32'h7FC00000 : {d_sgn, 8'hFF, 23'd0}};
            end else if (d_exp >= 11'd1151) begin
                cvt_data = {32'hFFFFFFFF, d_sgn, 8'hFF, 23'd0};
                cvt_nx   = 1'b1;
            end else begin
                if (d_exp >= 11'd897) begin
                    keep   = d_man[51:29];
                    guard  = d_man[28];
                    sticky = |d_man[27:0];
                    mag    = {d_exp[7:0] - 8'd128, keep};
                end else begin
                    // SP subnormal/zero: denormalise, clamping once everything is sticky
                    sh     = (d_exp < 11'd870) ? 11'd26 : 11'd896 - d_exp;
                    wide   = {(d_exp != 11'd0), d_man, 26'd0} >> sh;
                    keep   = wide[78:56];
                    guard  = wide[55];
                    sticky = |wide[54:0];
                    mag    = {8'd0, keep};
                end
                // round-up carry ripples into the exponent, producing inf on overflow
                round_up = guard & (sticky | keep[0]);
                cvt_data = {32'hFFFFFFFF, d_sgn, mag + {30'd0, round_up}};
                cvt_nx   = guard | sticky;
            end
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state       <= IDLE;
            op_q        <= '0;
            sp_dp_q     <= 1'b0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_nx_q    <= 1'b0;
            fflags_nx_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op_qual;
                sp_dp_q <= bus.in_req_sp_dp;
                tag_q   <= bus.in_req_tag;
            end
            if (state == BUSY && !bus.in_flush) begin
                rsp_data_q <= cvt_data;
                rsp_tag_q  <= tag_q;
                rsp_nx_q   <= cvt_nx & sp_dp_q;
            end
            if (rsp_hs && rsp_nx_q) fflags_nx_q <= 1'b1;
            else if (bus.in_fflags_clr) fflags_nx_q <= 1'b0;
        end
    end

    assign bus.out_req_ready = req_ready;
    assign bus.out_rsp_valid = (state == DONE);
    assign bus.out_rsp_data  = rsp_data_q;
    assign bus.out_rsp_tag   = rsp_tag_q;
    assign bus.out_rsp_nx    = rsp_nx_q;
    assign bus.out_fflags_nx = fflags_nx_q;
    assign bus.out_busy      = (state != IDLE);
endmodule

// File: tb/tb_fp_cvt_ctrl.sv
// tb/tb_fp_cvt_ctrl.sv - directed vector bench for fp_cvt_ctrl
module tb_fp_cvt_ctrl;
    typedef struct {
        logic [63:0] data;
        logic        sp_dp;
        logic [4:0]  tag;
        logic [63:0] exp_data;
        logic        exp_nx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec  = 0;
    int   n_miss = 0;
    logic exp_ff = 1'b0;
    vec_t vecs[14];

    fp_cvt_ctrl_if bus ();
    fp_cvt_ctrl dut (.in_clk(clk), .in_rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [63:0] d, input logic sd, input logic [4:0] t);
        bus.in_req_valid = 1'b1;
        bus.in_req_data  = d;
        bus.in_req_sp_dp = sd;
        bus.in_req_tag   = t;
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        int lat;
        drive_req(v.data, v.sp_dp, v.tag);
        #1 chk1($sformatf("v%0d_ready", idx), bus.out_req_ready, 1'b1);
        @(negedge clk);
        bus.in_req_valid = 1'b0;
        lat = 1;
        while (!bus.out_rsp_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk64($sformatf("v%0d_latency", idx), 64'(lat), 64'd2);
        chk64($sformatf("v%0d_data", idx), bus.out_rsp_data, v.exp_data);
        chk64($sformatf("v%0d_tag", idx), 64'(bus.out_rsp_tag), 64'(v.tag));
        chk1($sformatf("v%0d_nx", idx), bus.out_rsp_nx, v.exp_nx);
        bus.in_rsp_ready = 1'b1;
        @(negedge clk);
        bus.in_rsp_ready = 1'b0;
        exp_ff = exp_ff | v.exp_nx;
        chk1($sformatf("v%0d_fflags", idx), bus.out_fflags_nx, exp_ff);
        chk1($sformatf("v%0d_valid_drop", idx), bus.out_rsp_valid, 1'b0);
    endtask

    initial begin
        vecs[0]  = '{64'hFFFFFFFF_3F800000, 1'b0, 5'd3,  64'h3FF0000000000000, 1'b0};
        vecs[1]  = '{64'h3FF0000000000000, 1'b1, 5'd7,  64'hFFFFFFFF_3F800000, 1'b0};
        vecs[2]  = '{64'h3FF0000000000001, 1'b1, 5'd8,  64'hFFFFFFFF_3F800000, 1'b1};
        vecs[3]  = '{64'h00000000_3F800000, 1'b0, 5'd4,  64'h7FF8000000000000, 1'b0};
        vecs[4]  = '{64'hFFFFFFFF_C0200000, 1'b0, 5'd5,  64'hC004000000000000, 1'b0};
        vecs[5]  = '{64'hFFFFFFFF_7F800000, 1'b0, 5'd6,  64'h7FF0000000000000, 1'b0};
        vecs[6]  = '{64'hFFFFFFFF_00000001, 1'b0, 5'd9,  64'h36A0000000000000, 1'b0};
        vecs[7]  = '{64'h3FF0000030000000, 1'b1, 5'd10, 64'hFFFFFFFF_3F800002, 1'b1};
        vecs[8]  = '{64'h3FF0000010000000, 1'b1, 5'd11, 64'hFFFFFFFF_3F800000, 1'b1};
        vecs[9]  = '{64'h4800000000000000, 1'b1, 5'd12, 64'hFFFFFFFF_7F800000, 1'b1};
        vecs[10] = '{64'h3000000000000000, 1'b1, 5'd13, 64'hFFFFFFFF_00000000, 1'b1};
        vecs[11] = '{64'h3800000000000000, 1'b1, 5'd14, 64'hFFFFFFFF_00400000, 1'b0};
        vecs[12] = '{64'h7FF8000000000001, 1'b1, 5'd15, 64'hFFFFFFFF_7FC00000, 1'b0};
        vecs[13] = '{64'h47EFFFFFF0000000, 1'b1, 5'd31, 64'hFFFFFFFF_7F800000, 1'b1};

        rst = 1'b1;
        bus.in_flush = 1'b0;
        bus.in_req_valid = 1'b0;
        bus.in_req_data = '0;
        bus.in_req_sp_dp = 1'b0;
        bus.in_req_tag = '0;
        bus.in_rsp_ready = 1'b0;
        bus.in_fflags_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_ready", bus.out_req_ready, 1'b0);
        chk1("rst_valid", bus.out_rsp_valid, 1'b0);
        chk1("rst_busy", bus.out_busy, 1'b0);
        chk1("rst_fflags", bus.out_fflags_nx, 1'b0);
        chk64("rst_data", bus.out_rsp_data, 64'd0);
        rst = 1'b0;
        #1 chk1("idle_ready", bus.out_req_ready, 1'b1);
        @(negedge clk);

        // first inexact result is vecs[2], so fflags must stay 0 through vecs[0..1]
        for (int i = 0; i < 14; i++) do_txn(vecs[i], i);

        bus.in_fflags_clr = 1'b1;
        @(negedge clk);
        bus.in_fflags_clr = 1'b0;
        exp_ff = 1'b0;
        chk1("clr_alone", bus.out_fflags_nx, 1'b0);

        // backpressure, then handshake + new accept on the same edge
        drive_req(64'hFFFFFFFF_3F800000, 1'b0, 5'd9);
        @(negedge clk);
        drive_req(64'h3FF0000000000001, 1'b1, 5'd10);
        @(negedge clk);
        chk1("bp_valid", bus.out_rsp_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("bp_hold%0d_valid", i), bus.out_rsp_valid, 1'b1);
            chk64($sformatf("bp_hold%0d_data", i), bus.out_rsp_data, 64'h3FF0000000000000);
            chk64($sformatf("bp_hold%0d_tag", i), 64'(bus.out_rsp_tag), 64'd9);
            chk1($sformatf("bp_hold%0d_ready", i), bus.out_req_ready, 1'b0);
        end
        bus.in_rsp_ready = 1'b1;
        #1 chk1("b2b_ready", bus.out_req_ready, 1'b1);
        @(negedge clk);
        bus.in_rsp_ready = 1'b0;
        bus.in_req_valid = 1'b0;
        chk1("b2b_busy_valid", bus.out_rsp_valid, 1'b0);
        chk1("b2b_busy", bus.out_busy, 1'b1);
        @(negedge clk);
        chk1("b2b_valid", bus.out_rsp_valid, 1'b1);
        chk64("b2b_data", bus.out_rsp_data, 64'hFFFFFFFF_3F800000);
        chk64("b2b_tag", 64'(bus.out_rsp_tag), 64'd10);
        chk1("b2b_nx", bus.out_rsp_nx, 1'b1);

        // set and clear on the same edge: set wins
        bus.in_rsp_ready = 1'b1;
        bus.in_fflags_clr = 1'b1;
        @(negedge clk);
        bus.in_rsp_ready = 1'b0;
        chk1("race_set_wins", bus.out_fflags_nx, 1'b1);
        @(negedge clk);
        bus.in_fflags_clr = 1'b0;
        chk1("race_then_clr", bus.out_fflags_nx, 1'b0);

        // flush in BUSY with a competing request in the flush cycle
        drive_req(64'h3FF0000000000001, 1'b1, 5'd11);
        @(negedge clk);
        bus.in_flush = 1'b1;
        drive_req(64'h3FF0000000000001, 1'b1, 5'd12);
        #1 chk1("flush_ready", bus.out_req_ready, 1'b0);
        @(negedge clk);
        bus.in_flush = 1'b0;
        bus.in_req_valid = 1'b0;
        chk1("flush_busy", bus.out_busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1($sformatf("flush_novalid%0d", i), bus.out_rsp_valid, 1'b0);
            chk1($sformatf("flush_fflags%0d", i), bus.out_fflags_nx, 1'b0);
        end

        // reset while holding an inexact result in DONE with fflags set
        do_txn(vecs[2], 100);
        drive_req(64'h4800000000000000, 1'b1, 5'd12);
        @(negedge clk);
        bus.in_req_valid = 1'b0;
        @(negedge clk);
        chk1("pre_rst_valid", bus.out_rsp_valid, 1'b1);
        rst = 1'b1;
        bus.in_rsp_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.in_rsp_ready = 1'b0;
        chk1("mid_rst_valid", bus.out_rsp_valid, 1'b0);
        chk64("mid_rst_data", bus.out_rsp_data, 64'd0);
        chk64("mid_rst_tag", 64'(bus.out_rsp_tag), 64'd0);
        chk1("mid_rst_nx", bus.out_rsp_nx, 1'b0);
        chk1("mid_rst_fflags", bus.out_fflags_nx, 1'b0);
        chk1("mid_rst_busy", bus.out_busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
